// File: rtl/uart_mem_loader.sv
// UART boot loader: receives a framed image and writes it into firmware RAM.
// Keeps the CPU in reset while loading and auto-boots when no image shows up.
module uart_mem_loader #(
  parameter int          CLKS_PER_BIT   = 104,
  parameter int          MEM_WORDS      = 2048,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          BOOT_WAIT_CLKS = 24000000,
  parameter int          TIMEOUT_CLKS   = 1200000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rx,
  output logic        ld_active,
  output logic [31:0] ld_addr,
  output logic [31:0] ld_wdata,
  output logic [3:0]  ld_wmask,
  output logic        cpu_resetn,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(BOOT_WAIT_CLKS + 1);
  localparam int GW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_WAIT_CLKS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
    CKSUM,
    DONE,
    ERROR
  } state_t;

  state_t state, state_n;

  logic          rx_m, rx_s, rx_q;
  logic          rx_busy;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] clk_cnt;
  logic [7:0]    shreg;
  logic          byte_valid;
  logic          frame_err;

  logic [15:0]   len;
  logic [15:0]   word_idx;
  logic [1:0]    byte_k;
  logic [7:0]    sum;
  logic [BW-1:0] boot_cnt;
  logic [GW-1:0] gap_cnt;

  logic          in_frame;
  logic          is_sync;
  logic [31:0]   len_full;
  logic          last_word;

  // bit_cnt 0 is the start bit (half-bit sample), 1..8 data, 9 stop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_q       <= 1'b1;
      rx_busy    <= 1'b0;
      bit_cnt    <= '0;
      clk_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m       <= uart_rx;
      rx_s       <= rx_m;
      rx_q       <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!rx_busy) begin
        if (rx_q && !rx_s) begin
          rx_busy <= 1'b1;
          bit_cnt <= '0;
          clk_cnt <= '0;
        end
      end else if (clk_cnt == ((bit_cnt == 4'd0) ? HALF_LAST : BIT_LAST)) begin
        clk_cnt <= '0;
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd0) begin
          if (rx_s) rx_busy <= 1'b0;
        end else if (bit_cnt == 4'd9) begin
          rx_busy    <= 1'b0;
          byte_valid <= rx_s;
          frame_err  <= !rx_s;
        end else begin
          shreg <= {rx_s, shreg[7:1]};
        end
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
    end
  end

  assign in_frame  = (state == LEN_LO) || (state == LEN_HI) ||
                     (state == DATA) || (state == CKSUM);
  assign is_sync   = byte_valid && (shreg == SYNC_BYTE);
  assign len_full  = {16'd0, shreg, len[7:0]};
  assign last_word = (byte_k == 2'd3) && ((word_idx + 16'd1) == len);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= WAIT_SYNC;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      WAIT_SYNC: begin
        if (is_sync)                    state_n = LEN_LO;
        else if (boot_cnt == BOOT_LAST) state_n = DONE;
      end
      LEN_LO: if (byte_valid) state_n = LEN_HI;
      LEN_HI: begin
        if (byte_valid) begin
          if (len_full > 32'(MEM_WORDS)) state_n = ERROR;
          else if (len_full == 32'd0)    state_n = CKSUM;
          else                           state_n = DATA;
        end
      end
      DATA:  if (byte_valid && last_word) state_n = CKSUM;
      CKSUM: begin
        if (byte_valid) state_n = (shreg == sum) ? DONE : ERROR;
      end
      DONE:  state_n = DONE;
      ERROR: if (is_sync) state_n = LEN_LO;
      default: state_n = WAIT_SYNC;
    endcase
    if (in_frame && (frame_err || gap_cnt == GAP_LAST)) state_n = ERROR;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len      <= '0;
      word_idx <= '0;
      byte_k   <= '0;
      sum      <= '0;
      boot_cnt <= '0;
      gap_cnt  <= '0;
      ld_addr  <= '0;
      ld_wdata <= '0;
      ld_wmask <= '0;
    end else begin
      ld_wmask <= 4'h0;
      if (state == WAIT_SYNC) boot_cnt <= boot_cnt + BW'(1);
      if (!in_frame || byte_valid) gap_cnt <= '0;
      else                         gap_cnt <= gap_cnt + GW'(1);
      if (byte_valid) begin
        case (state)
          WAIT_SYNC, ERROR: begin
            if (is_sync) begin
              word_idx <= '0;
              byte_k   <= '0;
              sum      <= '0;
            end
          end
          LEN_LO: len[7:0]  <= shreg;
          LEN_HI: len[15:8] <= shreg;
          DATA: begin
            ld_wdata[8*byte_k +: 8] <= shreg;
            sum    <= sum + shreg;
            byte_k <= byte_k + 2'd1;
            if (byte_k == 2'd3) begin
              ld_wmask <= 4'hF;
              ld_addr  <= {14'd0, word_idx, 2'b00};
              word_idx <= word_idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ld_active  = (state != DONE);
  assign cpu_resetn = (state == DONE);
  assign done       = (state == DONE);
  assign err        = (state == ERROR);

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: auto-boot, good/bad frames,
// oversize length, framing error, inter-byte timeout and async reset.
module tb_uart_mem_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        uart_rx;
  logic        ld_active;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic [3:0]  ld_wmask;
  logic        cpu_resetn;
  logic        done;
  logic        err;

  int n_run  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int bad_mask = 0;
  logic [31:0] wr_addr [4];
  logic [31:0] wr_data [4];
  logic [7:0]  img [8] = '{8'h78, 8'h56, 8'h34, 8'h12,
                           8'hEF, 8'hBE, 8'hAD, 8'hDE};

  uart_mem_loader #(
    .CLKS_PER_BIT(CPB),
    .MEM_WORDS(2048),
    .SYNC_BYTE(8'hA5),
    .BOOT_WAIT_CLKS(1000),
    .TIMEOUT_CLKS(200)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .uart_rx(uart_rx),
    .ld_active(ld_active),
    .ld_addr(ld_addr),
    .ld_wdata(ld_wdata),
    .ld_wmask(ld_wmask),
    .cpu_resetn(cpu_resetn),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn && ld_wmask != 4'h0) begin
      if (ld_wmask != 4'hF) bad_mask++;
      if (wr_cnt < 4) begin
        wr_addr[wr_cnt] = ld_addr;
        wr_data[wr_cnt] = ld_wdata;
      end
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    wr_cnt   = 0;
    bad_mask = 0;
    resetn   = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_img(input logic [7:0] adj);
    logic [7:0] s;
    s = 8'h00;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) begin
      send_byte(img[i]);
      s = s + img[i];
    end
    send_byte(s + adj);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    uart_rx = 1'b1;
    resetn  = 1'b0;

    // reset values while held in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_active", 32'(ld_active), 32'd1);
    chk("rst_cpu", 32'(cpu_resetn), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mask", 32'(ld_wmask), 32'd0);
    chk("rst_addr", ld_addr, 32'd0);
    chk("rst_wdata", ld_wdata, 32'd0);

    // 1: idle line auto-boots around cycle 1000
    do_reset();
    repeat (990) @(posedge clk);
    @(negedge clk);
    chk("boot_early", 32'(done), 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("boot_done", 32'(done), 32'd1);
    chk("boot_cpu", 32'(cpu_resetn), 32'd1);
    chk("boot_active", 32'(ld_active), 32'd0);
    chk("boot_writes", wr_cnt, 32'd0);

    // 2: good two-word image
    do_reset();
    send_img(8'h00);
    chk("img_writes", wr_cnt, 32'd2);
    chk("img_addr0", wr_addr[0], 32'h0);
    chk("img_data0", wr_data[0], 32'h12345678);
    chk("img_addr1", wr_addr[1], 32'h4);
    chk("img_data1", wr_data[1], 32'hDEADBEEF);
    chk("img_done", 32'(done), 32'd1);
    chk("img_err", 32'(err), 32'd0);
    chk("img_active", 32'(ld_active), 32'd0);
    chk("img_mask", bad_mask, 32'd0);

    // 3: bad checksum, then recovery with a correct frame
    do_reset();
    send_img(8'h01);
    chk("ck_err", 32'(err), 32'd1);
    chk("ck_cpu", 32'(cpu_resetn), 32'd0);
    chk("ck_done", 32'(done), 32'd0);
    chk("ck_active", 32'(ld_active), 32'd1);
    send_img(8'h00);
    chk("ck_re_err", 32'(err), 32'd0);
    chk("ck_re_done", 32'(done), 32'd1);
    chk("ck_re_writes", wr_cnt, 32'd4);

    // 4: N = 2049 is rejected
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h08);
    settle();
    chk("big_err", 32'(err), 32'd1);
    chk("big_writes", wr_cnt, 32'd0);

    // 5: framing error in data byte 2, then empty image
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h78);
    send_byte(8'h56, 1'b0);
    settle();
    chk("fe_err", 32'(err), 32'd1);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    settle();
    chk("fe_done", 32'(done), 32'd1);
    chk("fe_err_clr", 32'(err), 32'd0);
    chk("fe_writes", wr_cnt, 32'd0);

    // 6: inter-byte timeout, then async reset mid-byte
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    settle();
    chk("to_wait", 32'(err), 32'd0);
    repeat (250) @(posedge clk);
    @(negedge clk);
    chk("to_err", 32'(err), 32'd1);
    chk("to_writes", wr_cnt, 32'd0);
    uart_rx = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("ar_err", 32'(err), 32'd0);
    chk("ar_active", 32'(ld_active), 32'd1);
    chk("ar_cpu", 32'(cpu_resetn), 32'd0);
    chk("ar_wdata", ld_wdata, 32'd0);
    chk("ar_mask", 32'(ld_wmask), 32'd0);
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    wr_cnt = 0;
    resetn = 1'b1;
    repeat (8) @(posedge clk);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    settle();
    chk("ar_done", 32'(done), 32'd1);
    chk("ar_writes", wr_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
